// File: rtl/complex_extend.sv
// Complex sample sign-extender with per-sample left-shift gain and a registered skid buffer.
// Optional macro COMPLEX_EXTEND_CONJ_EN adds the conj port (negates the imaginary output).
module complex_extend #(
    parameter int S_WIDTH = 16,
    parameter int M_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [2*S_WIDTH-1:0]                s_data,
    input  logic [$clog2(M_WIDTH-S_WIDTH)-1:0]  shift,
`ifdef COMPLEX_EXTEND_CONJ_EN
    input  logic                                conj,
`endif
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [2*M_WIDTH-1:0]                m_data
);

    localparam int SH_W   = $clog2(M_WIDTH - S_WIDTH);
    localparam int MAX_SH = M_WIDTH - S_WIDTH - 1;

    logic [SH_W-1:0]      eff_shift;
    logic [2*M_WIDTH-1:0] in_ext;

    // Clamping the shift keeps the extended value inside M_WIDTH bits, so no overflow is possible.
    assign eff_shift = (shift > SH_W'(MAX_SH)) ? SH_W'(MAX_SH) : shift;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic [S_WIDTH-1:0] comp;
            logic [M_WIDTH-1:0] ext;
            logic [M_WIDTH-1:0] shifted;
            logic [M_WIDTH-1:0] result;

            assign comp    = s_data[gi*S_WIDTH +: S_WIDTH];
            assign ext     = {{(M_WIDTH-S_WIDTH){comp[S_WIDTH-1]}}, comp};
            assign shifted = ext << eff_shift;

            if (gi == 1) begin : g_imag
`ifdef COMPLEX_EXTEND_CONJ_EN
                // The headroom bit left by the clamp lets -2^(S_WIDTH-1) negate without wrapping.
                assign result = conj ? (M_WIDTH'(0) - shifted) : shifted;
`else
                assign result = shifted;
`endif
            end else begin : g_real
                assign result = shifted;
            end

            assign in_ext[gi*M_WIDTH +: M_WIDTH] = result;
        end
    endgenerate

    logic [2*M_WIDTH-1:0] out_data_reg,  out_data_next;
    logic                 out_valid_reg, out_valid_next;
    logic [2*M_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                 skid_valid_reg, skid_valid_next;
    logic                 s_ready_reg;
    logic                 accept;

    assign accept = s_valid && s_ready_reg;

    always_comb begin
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;
        if (!out_valid_reg || m_ready) begin
            // Output register frees up: the skid has priority to preserve ordering.
            if (skid_valid_reg) begin
                out_data_next   = skid_data_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_data_next  = in_ext;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_data_next  = in_ext;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            s_ready_reg    <= 1'b0;
        end else begin
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_valid_reg <= skid_valid_next;
            // Registered from next-state only, so m_ready never reaches s_ready combinationally.
            s_ready_reg    <= !skid_valid_next;
        end
    end

    assign s_ready = s_ready_reg;
    assign m_valid = out_valid_reg;
    assign m_data  = out_data_reg;

endmodule

// File: tb/tb_complex_extend.sv
// Scoreboard bench for complex_extend: driver pushes expected samples, monitor pops on each output transfer.
module tb_complex_extend;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  shift;
    logic        conj;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;

`ifdef COMPLEX_EXTEND_CONJ_EN
    localparam bit CONJ_ON = 1'b1;
`else
    localparam bit CONJ_ON = 1'b0;
`endif

    complex_extend #(.S_WIDTH(16), .M_WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .shift   (shift),
`ifdef COMPLEX_EXTEND_CONJ_EN
        .conj    (conj),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_q[$];
    bit          random_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference: arithmetic scaling by 2^sh on wide signed integers.
    function automatic logic [63:0] model(input logic [31:0] d, input int sh, input logic cj);
        longint re, im;
        re = longint'($signed(d[15:0])) * (longint'(1) << sh);
        im = longint'($signed(d[31:16])) * (longint'(1) << sh);
        if (cj && CONJ_ON) im = -im;
        return {im[31:0], re[31:0]};
    endfunction

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [31:0] d, input logic [3:0] sh, input logic cj, input logic [63:0] exp_v);
        s_valid = 1'b1;
        s_data  = d;
        shift   = sh;
        conj    = cj;
        for (int t = 0; t < 200; t++) begin
            if (s_ready) begin
                exp_q.push_back(exp_v);
                $display("send data=%h shift=%0d conj=%0b expect=%h", d, sh, cj, exp_v);
                @(negedge clk);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_total++;
        $display("FAIL send_timeout: got s_ready=0 for 200 cycles expected acceptance");
        s_valid = 1'b0;
    endtask

    // Monitor samples just before each rising edge, when inputs and outputs are settled.
    initial begin
        logic        prev_hold;
        logic [63:0] held_data;
        prev_hold = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", {63'd0, m_valid}, 64'd1);
                    check("hold_data", m_data, held_data);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_out: got %h expected no output", m_data);
                    end else begin
                        logic [63:0] e;
                        e = exp_q.pop_front();
                        $display("recv data=%h expect=%h", m_data, e);
                        check("m_data", m_data, e);
                    end
                end
                prev_hold = m_valid && !m_ready;
                held_data = m_data;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  rs;
        logic        rc;
        longint      t0;

        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        shift   = '0;
        conj    = 1'b0;
        m_ready = 1'b0;
        random_done = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst", {63'd0, s_ready}, 64'd1);

        // Directed vectors, hand-computed.
        m_ready = 1'b1;
        send(32'h7FFF_8000, 4'd0, 1'b0, 64'h00007FFF_FFFF8000);
        check("latency_m_valid", {63'd0, m_valid}, 64'd1);
        send(32'h7FFF_8000, 4'd15, 1'b0, 64'h3FFF8000_C0000000);
        send(32'h0001_0001, 4'd1, 1'b0, 64'h00000002_00000002);
        send(32'hFFFF_0003, 4'd4, 1'b0, 64'hFFFFFFF0_00000030);
        send(32'h0000_0000, 4'd7, 1'b0, 64'h00000000_00000000);
        send(32'h8000_7FFF, 4'd15, 1'b0, 64'hC0000000_3FFF8000);
`ifdef COMPLEX_EXTEND_CONJ_EN
        send(32'h8000_0001, 4'd0, 1'b1, 64'h00008000_00000001);
        send(32'h0005_0002, 4'd2, 1'b1, 64'hFFFFFFEC_00000008);
`endif

        // Stall: output held, second sample lands in skid, s_ready drops.
        @(negedge clk);
        m_ready = 1'b0;
        send(32'h0003_0004, 4'd0, 1'b0, 64'h00000003_00000004);
        send(32'h0005_0006, 4'd2, 1'b0, 64'h00000014_00000018);
        s_valid = 1'b1;
        s_data  = 32'h0007_0008;
        repeat (2) @(negedge clk);
        check("stall_s_ready", {63'd0, s_ready}, 64'd0);
        check("stall_m_valid", {63'd0, m_valid}, 64'd1);
        check("stall_m_data", m_data, 64'h00000003_00000004);
        m_ready = 1'b1;
        send(32'h0007_0008, 4'd1, 1'b0, 64'h0000000E_00000010);

        // Reset with both registers full: nothing stale may come out afterwards.
        repeat (4) @(negedge clk);
        m_ready = 1'b0;
        send(32'h1111_2222, 4'd0, 1'b0, 64'h00001111_00002222);
        send(32'h3333_4444, 4'd0, 1'b0, 64'h00003333_00004444);
        check("full_s_ready", {63'd0, s_ready}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        check("midrst_s_ready", {63'd0, s_ready}, 64'd0);
        reset   = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("no_stale_m_valid", {63'd0, m_valid}, 64'd0);
        check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);

        // Random handshakes against the reference model.
        fork
            begin
                while (!random_done) begin
                    @(negedge clk);
                    m_ready = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    rd = $urandom;
                    rs = 4'($urandom_range(0, 15));
                    rc = 1'($urandom_range(0, 1));
                    send(rd, rs, rc, model(rd, int'(rs), rc));
                end
                random_done = 1'b1;
            end
        join
        @(negedge clk);
        m_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        // Full throughput: one sample per cycle with both sides held high.
        t0 = longint'($time);
        for (int i = 0; i < 20; i++) begin
            rd = 32'h0101_0000 * 32'(i) + 32'(i);
            send(rd, 4'(i % 16), 1'b0, model(rd, i % 16, 1'b0));
        end
        check("throughput_cycles", 64'((longint'($time) - t0) / 10), 64'd20);
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
        check("final_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/complex_extend.md
COMPLEX_EXTEND -- requirements
Module: complex_extend

Interface
REQ-001 The module SHALL have parameter S_WIDTH, default 16, giving the input component width in bits.
REQ-002 The module SHALL have parameter M_WIDTH, default 32, giving the output component width in bits; M_WIDTH > S_WIDTH+1 is required.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-005 The module SHALL have port s_valid, input, 1 bit, input sample valid.
REQ-006 The module SHALL have port s_ready, output, 1 bit, input sample accepted when high with s_valid.
REQ-007 The module SHALL have port s_data, input, 2*S_WIDTH bits: real in [S_WIDTH-1:0], imaginary in [2*S_WIDTH-1:S_WIDTH], two's complement.
REQ-008 The module SHALL have port shift, input, $clog2(M_WIDTH-S_WIDTH) bits, the left-shift gain for the sample.
REQ-009 The module SHALL have port m_valid, output, 1 bit, output sample valid.
REQ-010 The module SHALL have port m_ready, input, 1 bit, downstream accept.
REQ-011 The module SHALL have port m_data, output, 2*M_WIDTH bits: real in [M_WIDTH-1:0], imaginary in [2*M_WIDTH-1:M_WIDTH].
REQ-012 The module SHALL have port conj, input, 1 bit, negate imaginary part; present only with COMPLEX_EXTEND_CONJ_EN.

Function
REQ-013 The module SHALL transfer a sample on any rising edge where s_valid && s_ready, sampling s_data, shift and conj together.
REQ-014 Each component SHALL be sign-extended to M_WIDTH, then shifted left by min(shift, M_WIDTH-S_WIDTH-1), zero-filling the LSBs; the result never overflows.
REQ-015 Real and imaginary components SHALL be processed identically and in lockstep; one valid/ready pair covers both.
REQ-016 The datapath SHALL consist of an output register plus one skid register.
REQ-017 Latency SHALL be one cycle: a sample accepted at edge k SHALL be presented on m_data with m_valid high after edge k, provided the output register was empty or drained at edge k.
REQ-018 s_ready SHALL be a registered signal, high exactly when the skid register is empty, with no combinational path from m_ready.
REQ-019 If the output register is held (m_valid && !m_ready) when a sample is accepted, that sample SHALL go to the skid register and s_ready SHALL drop after that edge.
REQ-020 On an edge with m_valid && m_ready, the output register SHALL load the skid content if the skid is full, else the newly accepted sample if any, else m_valid SHALL go low.
REQ-021 m_data and m_valid SHALL remain stable while m_valid && !m_ready.
REQ-022 Sustained s_valid and m_ready high SHALL yield one sample per cycle.
REQ-023 Samples SHALL be emitted in acceptance order with none dropped or duplicated.

Reset
REQ-024 While reset is low at an edge, m_valid SHALL be 0, s_ready SHALL be 0, the skid SHALL be empty and m_data SHALL be 0.
REQ-025 s_ready SHALL go high on the first edge after reset returns high.
REQ-026 Reset asserted mid-stream SHALL discard held and skid samples without emitting them.

Configuration
REQ-027 With macro COMPLEX_EXTEND_CONJ_EN defined, the conj port SHALL exist, and when conj is 1 the imaginary output SHALL be the negation of the extended, shifted imaginary input; -2^(S_WIDTH-1) SHALL map to +2^(S_WIDTH-1) scaled, without wrap.
REQ-028 With COMPLEX_EXTEND_CONJ_EN undefined, the conj port SHALL be absent and the imaginary path SHALL match the real path.

Verification
REQ-029 Scenario (S=16, M=32): s_data=0x7FFF_8000, shift=0 -> m_data=0x00007FFF_FFFF8000 one cycle after acceptance.
REQ-030 Scenario: s_data=0x7FFF_8000, shift=15 -> real 0xC0000000, imag 0x3FFF8000.
REQ-031 Scenario: m_ready low for 3 cycles with s_valid high -> one sample held, one in skid, s_ready low; when m_ready rises, both are emitted in order with no loss.
REQ-032 Scenario: random s_valid and m_ready over 10000 samples -> output equals the reference model in order; full throughput when both are held high.
REQ-033 Scenario (COMPLEX_EXTEND_CONJ_EN, conj=1): s_data=0x8000_0001, shift=0 -> real 0x00000001, imag 0x00008000.
REQ-034 Scenario: reset pulled low with both registers full -> m_valid=0 and s_ready=0 on the next edge; no stale sample is emitted after release.
